// File: rtl/serial_to_parallel_if.sv
// Serial receive bundle for serial_to_parallel: bit stream, framing control and
// the valid/ready word output. master = bit producer/consumer side, slave = receiver.
interface serial_to_parallel_if #(
    parameter int WIDTH = 8
);
    logic             bit_valid;
    logic             serial_in;
    logic             right_left;
    logic             clear;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    logic             busy;
    logic             frame_err;

    modport master (
        output bit_valid, serial_in, right_left, clear, data_ready,
        input  data_out, data_valid, overrun, busy, frame_err
    );

    modport slave (
        input  bit_valid, serial_in, right_left, clear, data_ready,
        output data_out, data_valid, overrun, busy, frame_err
    );
endinterface

// File: rtl/serial_to_parallel.sv
// Rebuilds WIDTH-bit words from a serial bit stream (per-frame LSB/MSB-first order),
// with a one-word valid/ready holding register and sticky overrun. Optional macro
// SERIAL_TIMEOUT_EN drops stalled partial frames after TIMEOUT idle cycles.
module serial_to_parallel #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_to_parallel_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] count_r;
    logic             order_r;
    logic [WIDTH-1:0] sr_r;
    logic [WIDTH-1:0] data_r;
    logic             valid_r;
    logic             overrun_r;

    logic             timeout_s;
    logic             take_bit_s;
    logic             order_s;
    logic [WIDTH-1:0] word_s;
    logic             complete_s;
    logic             load_s;
    logic             drop_s;

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_to_parallel: WIDTH must be >= 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("serial_to_parallel: TIMEOUT must be >= 1");
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: clear beats timeout, timeout beats an incoming bit
    always_comb begin
        state_s = state_r;
        if (bus.clear) begin
            state_s = IDLE;
        end else if (timeout_s) begin
            state_s = IDLE;
        end else if (take_bit_s) begin
            case (state_r)
                IDLE:    state_s = COLLECT;
                COLLECT: state_s = complete_s ? IDLE : COLLECT;
                default: state_s = IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // FSM outputs: per-cycle strobes driving the datapath
    always_comb begin
        take_bit_s = bus.bit_valid && !bus.clear && !timeout_s;
        order_s    = (state_r == IDLE) ? bus.right_left : order_r;
        if (order_s) begin
            word_s = {bus.serial_in, sr_r[WIDTH-1:1]};
        end else begin
            word_s = {sr_r[WIDTH-2:0], bus.serial_in};
        end
        complete_s = take_bit_s && (state_r == COLLECT) && (count_r == CNT_W'(WIDTH - 1));
        load_s     = complete_s && (!valid_r || bus.data_ready);
        drop_s     = complete_s && valid_r && !bus.data_ready;
    end

    // Frame assembly: shift register, bit count and latched bit order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
            order_r <= 1'b0;
            sr_r    <= '0;
        end else if (bus.clear || timeout_s) begin
            count_r <= '0;
            sr_r    <= '0;
        end else if (take_bit_s) begin
            sr_r    <= word_s;
            order_r <= order_s;
            count_r <= complete_s ? '0 : count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Holding register: a completed word is kept unless the slot is full and not being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r    <= '0;
            valid_r   <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            if (load_s) begin
                data_r  <= word_s;
                valid_r <= 1'b1;
            end else if (valid_r && bus.data_ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (bus.clear) begin
                overrun_r <= 1'b0;
            end else if (drop_s) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

`ifdef SERIAL_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt_r;
    logic              frame_err_r;

    // Timeout fires once TIMEOUT bit-less cycles have been counted in COLLECT
    always_comb begin
        timeout_s = (state_r == COLLECT) && (idle_cnt_r == IDLE_W'(TIMEOUT)) && !bus.clear;
    end

    // Idle counter runs only while collecting and restarts on every bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else if (bus.clear || (state_r == IDLE) || bus.bit_valid || timeout_s) begin
            idle_cnt_r <= '0;
        end else if (idle_cnt_r != IDLE_W'(TIMEOUT)) begin
            idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // One-cycle frame error pulse following a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= timeout_s;
        end
    end

    assign bus.frame_err = frame_err_r;
`else
    assign timeout_s     = 1'b0;
    assign bus.frame_err = 1'b0;
`endif

    assign bus.data_out   = data_r;
    assign bus.data_valid = valid_r;
    assign bus.overrun    = overrun_r;
    assign bus.busy       = (state_r == COLLECT);
endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: a vector table of whole frames plus
// hand-written overrun, same-edge handshake, reset/clear and timeout sequences.
module tb_serial_to_parallel;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   busy_err;
    int   pulses;

    serial_to_parallel_if #(.WIDTH(8)) bus ();

    serial_to_parallel #(.WIDTH(8), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rl;
        logic       flip;
        logic [7:0] tx;
        int         gap;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // tx[7] goes on the wire first; bits first_i .. first_i+n-1 are sent
    task automatic send_bits(input logic [7:0] tx, input logic rl, input logic flip,
                             input int gap, input int first_i, input int n);
        for (int i = first_i; i < first_i + n; i++) begin
            bus.bit_valid  = 1'b1;
            bus.serial_in  = tx[7-i];
            bus.right_left = (flip && i > 0) ? ~rl : rl;
            tick();
            bus.bit_valid  = 1'b0;
            if (i < 7) begin
                if (bus.busy !== 1'b1) busy_err++;
                for (int g = 0; g < gap; g++) begin
                    tick();
                    if (bus.busy !== 1'b1) busy_err++;
                end
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        busy_err = 0;
        rst_n          = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.serial_in  = 1'b0;
        bus.right_left = 1'b1;
        bus.clear      = 1'b0;
        bus.data_ready = 1'b1;

        vecs[0] = '{rl: 1'b1, flip: 1'b0, tx: 8'b1010_0101, gap: 0, exp: 8'hA5};
        vecs[1] = '{rl: 1'b0, flip: 1'b0, tx: 8'b0011_1100, gap: 2, exp: 8'h3C};
        vecs[2] = '{rl: 1'b1, flip: 1'b0, tx: 8'b1000_0000, gap: 0, exp: 8'h01};
        vecs[3] = '{rl: 1'b0, flip: 1'b0, tx: 8'b1000_0000, gap: 0, exp: 8'h80};
        vecs[4] = '{rl: 1'b1, flip: 1'b1, tx: 8'b1100_1010, gap: 1, exp: 8'h53};
        vecs[5] = '{rl: 1'b0, flip: 1'b1, tx: 8'b1111_0000, gap: 0, exp: 8'hF0};
        vecs[6] = '{rl: 1'b1, flip: 1'b0, tx: 8'b0000_0001, gap: 3, exp: 8'h80};

        tick();
        tick();
        check("reset data_out", {24'd0, bus.data_out}, 32'h0);
        check("reset data_valid", {31'd0, bus.data_valid}, 32'h0);
        check("reset overrun", {31'd0, bus.overrun}, 32'h0);
        check("reset busy", {31'd0, bus.busy}, 32'h0);
        check("reset frame_err", {31'd0, bus.frame_err}, 32'h0);
        rst_n = 1'b1;
        tick();

        // whole frames with the consumer always ready
        for (int v = 0; v < 7; v++) begin
            busy_err = 0;
            send_bits(vecs[v].tx, vecs[v].rl, vecs[v].flip, vecs[v].gap, 0, 8);
            check($sformatf("vec%0d busy during frame", v), busy_err, 32'd0);
            check($sformatf("vec%0d data_valid", v), {31'd0, bus.data_valid}, 32'h1);
            check($sformatf("vec%0d data_out", v), {24'd0, bus.data_out}, {24'd0, vecs[v].exp});
            check($sformatf("vec%0d overrun", v), {31'd0, bus.overrun}, 32'h0);
            check($sformatf("vec%0d busy after", v), {31'd0, bus.busy}, 32'h0);
            tick();
            check($sformatf("vec%0d valid one cycle", v), {31'd0, bus.data_valid}, 32'h0);
        end

        // overrun: second word dropped while the first is unconsumed
        bus.data_ready = 1'b0;
        send_bits(8'h11, 1'b0, 1'b0, 0, 0, 8);
        check("ovr first valid", {31'd0, bus.data_valid}, 32'h1);
        check("ovr first data", {24'd0, bus.data_out}, 32'h11);
        send_bits(8'h22, 1'b0, 1'b0, 0, 0, 8);
        check("ovr kept data", {24'd0, bus.data_out}, 32'h11);
        check("ovr flag", {31'd0, bus.overrun}, 32'h1);
        bus.data_ready = 1'b1;
        tick();
        check("ovr drained valid", {31'd0, bus.data_valid}, 32'h0);
        check("ovr sticky", {31'd0, bus.overrun}, 32'h1);
        tick();
        check("ovr still sticky", {31'd0, bus.overrun}, 32'h1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("ovr cleared", {31'd0, bus.overrun}, 32'h0);

        // completion on the same edge as the handshake replaces the word
        bus.data_ready = 1'b0;
        send_bits(8'h11, 1'b0, 1'b0, 0, 0, 8);
        send_bits(8'h22, 1'b0, 1'b0, 0, 0, 7);
        bus.data_ready = 1'b1;
        send_bits(8'h22, 1'b0, 1'b0, 0, 7, 1);
        check("same-edge data", {24'd0, bus.data_out}, 32'h22);
        check("same-edge valid", {31'd0, bus.data_valid}, 32'h1);
        check("same-edge overrun", {31'd0, bus.overrun}, 32'h0);
        tick();
        check("same-edge drained", {31'd0, bus.data_valid}, 32'h0);

        // async reset mid-frame discards the partial frame
        send_bits(8'hF0, 1'b1, 1'b0, 0, 0, 4);
        rst_n = 1'b0;
        #3;
        check("midreset busy", {31'd0, bus.busy}, 32'h0);
        check("midreset valid", {31'd0, bus.data_valid}, 32'h0);
        rst_n = 1'b1;
        tick();
        send_bits(8'h81, 1'b1, 1'b0, 0, 0, 8);
        check("post-reset data", {24'd0, bus.data_out}, 32'h81);
        check("post-reset valid", {31'd0, bus.data_valid}, 32'h1);
        tick();

        // clear after 5 bits, colliding with a bit that must be discarded
        send_bits(8'hFF, 1'b0, 1'b0, 0, 0, 5);
        bus.clear     = 1'b1;
        bus.bit_valid = 1'b1;
        bus.serial_in = 1'b1;
        tick();
        bus.clear     = 1'b0;
        bus.bit_valid = 1'b0;
        check("clear busy", {31'd0, bus.busy}, 32'h0);
        send_bits(8'h96, 1'b0, 1'b0, 0, 0, 8);
        check("post-clear data", {24'd0, bus.data_out}, 32'h96);
        check("post-clear valid", {31'd0, bus.data_valid}, 32'h1);
        tick();

        // stalled partial frame
        pulses = 0;
        send_bits(8'h5A, 1'b0, 1'b0, 0, 0, 3);
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.frame_err === 1'b1) pulses++;
        end
`ifdef SERIAL_TIMEOUT_EN
        check("timeout pulses", pulses, 32'd1);
        check("timeout busy", {31'd0, bus.busy}, 32'h0);
        send_bits(8'h5A, 1'b0, 1'b0, 0, 0, 8);
`else
        check("no-timeout pulses", pulses, 32'd0);
        check("no-timeout busy", {31'd0, bus.busy}, 32'h1);
        send_bits(8'h5A, 1'b0, 1'b0, 0, 3, 5);
`endif
        check("stall word data", {24'd0, bus.data_out}, 32'h5A);
        check("stall word valid", {31'd0, bus.data_valid}, 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
